// File: rtl/text_render_ctrl_if.sv
// Read-side bus of the text renderer: text VRAM read port plus the font_dev lookup.
// master = renderer (drives address/glyph select), slave = VRAM + font ROM side.
interface text_render_ctrl_if;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic [7:0]  font_ascii;
  logic [3:0]  font_row;
  logic [2:0]  font_col;
  logic        font_data;

  modport master (
    output vram_addr, font_ascii, font_row, font_col,
    input  vram_data, font_data
  );

  modport slave (
    input  vram_addr, font_ascii, font_row, font_col,
    output vram_data, font_data
  );
endinterface

// File: rtl/text_render_ctrl.sv
// Text-mode render sequencer: 3-stage pix_en pipeline (cell/VRAM, glyph select, colour).
// Optional cursor blinking is enabled by defining CURSOR_BLINK_EN.
module text_render_ctrl #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_en,
  input  logic [9:0]                 h_cnt,
  input  logic [9:0]                 v_cnt,
  input  logic                       video_on,
  input  logic                       hs_in,
  input  logic                       vs_in,
  input  logic                       cursor_en,
  input  logic [6:0]                 cursor_x,
  input  logic [4:0]                 cursor_y,
  text_render_ctrl_if.master         bus,
  output logic [11:0]                rgb,
  output logic                       hs_out,
  output logic                       vs_out
);

  logic [6:0]  ccol;
  logic [4:0]  cline;
  logic [3:0]  crow;
  logic [2:0]  cx;
  logic [11:0] addr_next;
  logic        blank_next;
  logic        hit_next;
  logic        blink_vis;

  // The full line index v_cnt[9:4] is used for the range test so lines past 511
  // never alias back onto the top rows.
  always_comb begin
    ccol       = h_cnt[9:3];
    cline      = v_cnt[8:4];
    crow       = v_cnt[3:0];
    cx         = h_cnt[2:0];
    addr_next  = 12'({cline, 6'b0}) + 12'({cline, 4'b0}) + 12'(ccol);
    blank_next = !video_on || (32'(ccol) >= COLS) || (32'(v_cnt[9:4]) >= ROWS);
    hit_next   = cursor_en && (ccol == cursor_x) && (cline == cursor_y) &&
                 (crow >= 4'd14) && blink_vis;
  end

`ifdef CURSOR_BLINK_EN
  logic        vs_prev;
  logic [15:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev   <= 1'b1;
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (pix_en) begin
      vs_prev <= vs_in;
      if (vs_prev && !vs_in) begin
        if (blink_cnt == 16'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_vis <= ~blink_vis;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign blink_vis = 1'b1;
`endif

  // Stage 0: cell decode and VRAM address; the valid flag marks a refilled slot.
  logic [3:0] s0_crow;
  logic [2:0] s0_cx;
  logic       s0_valid, s0_blank, s0_hs, s0_vs, s0_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vram_addr <= '0;
      s0_crow       <= '0;
      s0_cx         <= '0;
      s0_valid      <= 1'b0;
      s0_blank      <= 1'b0;
      s0_hs         <= 1'b1;
      s0_vs         <= 1'b1;
      s0_cur        <= 1'b0;
    end else if (pix_en) begin
      bus.vram_addr <= addr_next;
      s0_crow       <= crow;
      s0_cx         <= cx;
      s0_valid      <= 1'b1;
      s0_blank      <= blank_next;
      s0_hs         <= hs_in;
      s0_vs         <= vs_in;
      s0_cur        <= hit_next;
    end
  end

  // Stage 1: glyph select; column is inverted because font bit 7 is the leftmost pixel.
  logic s1_valid, s1_blank, s1_hs, s1_vs, s1_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.font_ascii <= '0;
      bus.font_row   <= '0;
      bus.font_col   <= '0;
      s1_valid       <= 1'b0;
      s1_blank       <= 1'b0;
      s1_hs          <= 1'b1;
      s1_vs          <= 1'b1;
      s1_cur         <= 1'b0;
    end else if (pix_en) begin
      bus.font_ascii <= bus.vram_data;
      bus.font_row   <= s0_crow;
      bus.font_col   <= ~s0_cx;
      s1_valid       <= s0_valid;
      s1_blank       <= s0_blank;
      s1_hs          <= s0_hs;
      s1_vs          <= s0_vs;
      s1_cur         <= s0_cur;
    end
  end

  // Stage 2: colour; empty slots after reset render as black.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb    <= '0;
      hs_out <= 1'b1;
      vs_out <= 1'b1;
    end else if (pix_en) begin
      if (!s1_valid || s1_blank) begin
        rgb <= 12'h000;
      end else begin
        rgb <= (bus.font_data ^ s1_cur) ? FG_COLOR : BG_COLOR;
      end
      hs_out <= s1_hs;
      vs_out <= s1_vs;
    end
  end

endmodule

// File: tb/tb_text_render_ctrl.sv
// Bench for text_render_ctrl: directed steps plus random pixels against a
// pixel-coordinate reference model; build with CURSOR_BLINK_EN to cover blinking.
module tb_text_render_ctrl;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;
  localparam int BLINK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [9:0]  h_cnt, v_cnt;
  logic        video_on, hs_in, vs_in;
  logic        cursor_en;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [11:0] rgb;
  logic        hs_out, vs_out;

  text_render_ctrl_if bus();

  text_render_ctrl #(.BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .video_on(video_on),
    .hs_in(hs_in), .vs_in(vs_in),
    .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .bus(bus),
    .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // VRAM (registered read) and font_dev (combinational) models
  logic [7:0] vram [0:4095];
  always @(posedge clk) bus.vram_data <= vram[bus.vram_addr];

  function automatic logic [7:0] font_byte(input logic [7:0] a, input logic [3:0] r);
    logic [7:0] b;
    if (a == 8'h20)                  b = 8'h00;
    else if (a == 8'h41 && r == 4'd5) b = 8'h18;
    else                             b = (a * 8'd37) ^ ({4'b0, r} * 8'd29) ^ 8'h5A;
    return b;
  endfunction

  logic [7:0] font_line;
  assign font_line    = font_byte(bus.font_ascii, bus.font_row);
  assign bus.font_data = font_line[bus.font_col];

  // scoreboard
  int          checks = 0;
  int          failures = 0;
  logic [13:0] exp_q[$];
  int          falls;
  logic        prev_vs;
  int          last_h, last_v;
  bit          last_valid;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_blink();
`ifdef CURSOR_BLINK_EN
    return ((falls / BLINK) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [11:0] model_rgb(input int h, input int v, input bit von,
                                            input bit cen, input int cx, input int cy,
                                            input bit vis);
    logic [7:0] ch, bits;
    bit         lit, cur;
    if (!von || h >= 640 || v >= 480) return 12'h000;
    ch   = vram[(v / 16) * 80 + h / 8];
    bits = font_byte(ch, 4'(v % 16));
    lit  = bits[7 - (h % 8)];
    cur  = cen && (h / 8 == cx) && (v / 16 == cy) && (v % 16 >= 14) && vis;
    return (lit ^ cur) ? FG : BG;
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pix_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q = {};
    exp_q.push_back({12'h000, 1'b1, 1'b1});
    exp_q.push_back({12'h000, 1'b1, 1'b1});
    falls = 0;
    prev_vs = 1'b1;
    last_valid = 1'b0;
  endtask

  // One pix_en strobe, then a gap clock so VRAM data is ready for the next strobe.
  task automatic step(input int h, input int v, input bit von, input bit hs, input bit vs,
                      input bit cen, input int cx, input int cy);
    logic [13:0] e;
    @(negedge clk);
    h_cnt = 10'(h); v_cnt = 10'(v); video_on = von; hs_in = hs; vs_in = vs;
    cursor_en = cen; cursor_x = 7'(cx); cursor_y = 5'(cy);
    pix_en = 1'b1;
    exp_q.push_back({model_rgb(h, v, von, cen, cx, cy, model_blink()), hs, vs});
    if (prev_vs && !vs) falls++;
    prev_vs = vs;
    @(negedge clk);
    pix_en = 1'b0;
    e = exp_q.pop_front();
    check("rgb", 16'(rgb), 16'(e[13:2]));
    check("hs_out", 16'(hs_out), 16'(e[1]));
    check("vs_out", 16'(vs_out), 16'(e[0]));
    check("vram_addr", 16'(bus.vram_addr), 16'(((v / 16) % 32) * 80 + h / 8));
    if (last_valid) begin
      check("font_col", 16'(bus.font_col), 16'(7 - (last_h % 8)));
      check("font_row", 16'(bus.font_row), 16'(last_v % 16));
    end
    last_h = h; last_v = v; last_valid = 1'b1;
  endtask

  task automatic blank_step(input int h);
    step(h, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; pix_en = 1'b0;
    h_cnt = '0; v_cnt = '0; video_on = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    cursor_en = 1'b0; cursor_x = '0; cursor_y = '0;
    for (int i = 0; i < 4096; i++) vram[i] = 8'($urandom_range(0, 255));
    vram[0]  = 8'h41;
    vram[82] = 8'h20;

    // reset state
    do_reset();
    check("reset_rgb", 16'(rgb), 16'h000);
    check("reset_hs", 16'(hs_out), 16'd1);
    check("reset_vs", 16'(vs_out), 16'd1);
    check("reset_addr", 16'(bus.vram_addr), 16'd0);
    check("reset_ascii", 16'(bus.font_ascii), 16'd0);

    // last cell address
    step(632, 479, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    check("addr_max", 16'(bus.vram_addr), 16'd2399);

    // glyph 'A' row 5 = 8'h18 across h 0..7
    for (int h = 0; h < 8; h++) step(h, 5, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int h = 8; h < 10; h++) step(h, 5, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);

    // blanking and an hsync pulse of width 4
    for (int h = 636; h < 712; h++)
      step(h, 100, h < 640, !(h >= 700 && h < 704), 1'b1, 1'b0, 0, 0);

    // reset mid-line with lit pixels and hsync low in flight
    step(3, 5, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    step(4, 5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(6, 5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    do_reset();
    check("midreset_rgb", 16'(rgb), 16'h000);
    check("midreset_hs", 16'(hs_out), 16'd1);
    check("midreset_vs", 16'(vs_out), 16'd1);
    check("midreset_addr", 16'(bus.vram_addr), 16'd0);
    for (int h = 0; h < 6; h++) step(h, 5, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);

    // cursor at (2,1) over a space: rows 30,31 lit, row 29 not, disabled -> BG
    for (int v = 29; v < 32; v++)
      for (int h = 16; h < 24; h++) step(h, v, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1);
    step(16, 31, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1);
    step(17, 31, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1);
    check("cursor_row31", 16'(rgb), 16'(FG));
    for (int h = 16; h < 24; h++) step(h, 30, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1);
    blank_step(640);
    blank_step(641);
    check("cursor_off", 16'(rgb), 16'(BG));

    // blink across frames: each frame renders the cursor pixel then a vsync fall
    do_reset();
    for (int f = 0; f < 5; f++) begin
      bit vis;
`ifdef CURSOR_BLINK_EN
      vis = (f < 2) || (f == 4);
`else
      vis = 1'b1;
`endif
      step(16, 30, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1);
      blank_step(640);
      blank_step(641);
      check("blink_frame", 16'(rgb), 16'(vis ? FG : BG));
      step(700, 490, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      step(700, 492, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    end

    // random pixels
    for (int n = 0; n < 400; n++) begin
      int h, v, cx, cy;
      bit von, cen;
      h = $urandom_range(0, 799);
      v = $urandom_range(0, 524);
      von = ($urandom_range(0, 7) != 0) ? (h < 640 && v < 480) : 1'($urandom_range(0, 1));
      cen = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        cx = h / 8;
        cy = (v / 16) % 32;
      end else begin
        cx = $urandom_range(0, 127);
        cy = $urandom_range(0, 31);
      end
      step(h, v, von, !(h >= 656 && h < 752), !(v == 490 || v == 491), cen, cx, cy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
